seq_multiplier: RTL
===================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width in bits, even, 8..64.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1: multiplier bits retired per CALC cycle; one of 1, 2, 4; divides XLEN.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: request present.
REQ-006 SHALL have port in_ready, output, 1: block accepts a request this cycle.
REQ-007 SHALL have port a, input, XLEN: multiplicand.
REQ-008 SHALL have port b, input, XLEN: multiplier.
REQ-009 SHALL have port sign_ctrl, input, 2: 00 both unsigned; 11 both signed; 01/10 a signed, b unsigned.
REQ-010 SHALL have port hi_sel, input, 1: 1 returns product[2*XLEN-1:XLEN], 0 returns product[XLEN-1:0].
REQ-011 SHALL have port flush, input, 1: abort any in-flight operation.
REQ-012 SHALL have port out_valid, output, 1: result valid.
REQ-013 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-014 SHALL have port result, output, XLEN: selected product half.

Function
REQ-015 SHALL implement states IDLE, CALC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 SHALL accept a request on in_valid & in_ready; it latches a, b, sign_ctrl and hi_sel and moves to CALC.
REQ-017 SHALL, on acceptance, store |a| if a is treated signed and a[XLEN-1]=1, else a; the same rule applies to b.
REQ-018 SHALL set neg = (a signed & a[MSB]) XOR (b signed & b[MSB]) on acceptance.
REQ-019 SHALL treat the magnitude of the most-negative value as unsigned 2^(XLEN-1), with no overflow.
REQ-020 SHALL retire BITS_PER_CYCLE multiplier bits per CALC cycle, LSB first, using shift-add into a 2*XLEN accumulator.
REQ-021 SHALL keep CALC for exactly N = XLEN/BITS_PER_CYCLE cycles, tracked by a down-counter; then it moves to DONE.
REQ-022 SHALL, on entering DONE, give the final product as the two's-complement negation of the accumulator when neg = 1, and as the accumulator otherwise, computed mod 2^(2*XLEN).
REQ-023 SHALL drive result from the final product per the latched hi_sel, held stable while out_valid = 1 and out_ready = 0.
REQ-024 SHALL move from DONE to IDLE on out_ready = 1; no new request is accepted in that same cycle, so issue-to-issue spacing is N+2 cycles minimum.
REQ-025 SHALL give latency from the acceptance edge to the first out_valid = 1 cycle of N+1 cycles (33 at defaults).
REQ-026 SHALL make flush = 1 force IDLE at the next edge from any state, drop any pending result and clear out_valid; flush takes priority over acceptance and over out_ready.
REQ-027 SHALL ignore a, b, sign_ctrl and hi_sel outside the acceptance cycle; operand changes during CALC do not affect the result.
REQ-028 SHALL hold result at 0 whenever out_valid = 0.
REQ-029 SHALL produce the correct product for zero operands; there is no early termination, and latency stays N+1.

Reset
REQ-030 SHALL, on rst_n = 0, set the state to IDLE immediately (asynchronous), with in_ready = 1, out_valid = 0, result = 0, and the accumulator, operand registers and counter at 0.
REQ-031 SHALL, when rst_n is asserted mid-CALC or in DONE, discard the operation; after release, the first valid request behaves as from power-up.
REQ-032 SHALL release reset on the clock edge: no state change on the edge where rst_n rises unless in_valid is sampled high with the block in IDLE.

Verification
REQ-033 SHALL cover, at XLEN=32, BPC=1: a=0xFFFFFFFF, b=0xFFFFFFFF, sign_ctrl=00, hi_sel=1 -> result 0xFFFFFFFE, out_valid 33 cycles after acceptance.
REQ-034 SHALL cover a=0xFFFFFFFF (-1), b=0x00000002, sign_ctrl=11, hi_sel=0 -> 0xFFFFFFFE; the same operands with hi_sel=1 -> 0xFFFFFFFF.
REQ-035 SHALL cover a=0x80000000, b=0x80000000, sign_ctrl=11, hi_sel=1 -> 0x40000000; sign_ctrl=01, a=0xFFFFFFFF, b=0xFFFFFFFF, hi_sel=1 -> 0xFFFFFFFF.
REQ-036 SHALL cover backpressure: out_ready held 0 for 10 cycles in DONE -> result stable, in_ready 0; out_ready=1 -> IDLE next cycle.
REQ-037 SHALL cover flush asserted at CALC cycle 5 -> IDLE next edge, no out_valid; a following request a=3, b=5, sign_ctrl=00 -> result 15.
REQ-038 SHALL cover a BPC=4 build: the same vectors give identical results with latency 9 cycles; reset asserted mid-CALC -> in_ready=1 and out_valid=0 without a clock edge.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with signed/unsigned operand control and hi/lo result select.
// Operands are reduced to magnitudes on acceptance; the sign is reapplied when the product is final.
module seq_multiplier #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [1:0]      sign_ctrl,
    input  logic            hi_sel,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int unsigned N     = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned AW    = 2 * XLEN;
    localparam int unsigned PW    = XLEN + BITS_PER_CYCLE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              hi_sel_q, hi_sel_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_neg;
    logic              b_neg;
    logic [PW-1:0]     partial;
    logic [PW-1:0]     sum;
    logic [AW-1:0]     acc_step;
    logic [AW-1:0]     prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            hi_sel_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            hi_sel_q    <= hi_sel_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    // Datapath step: add multiplicand times the low multiplier bits into the upper half, then shift right.
    always_comb begin
        a_neg   = (sign_ctrl != 2'b00) && a[XLEN-1];
        b_neg   = (sign_ctrl == 2'b11) && b[XLEN-1];
        partial = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) begin
                partial = partial + (PW'(mcand_q) << i);
            end
        end
        sum      = PW'(acc_q[AW-1:XLEN]) + partial;
        acc_step = AW'({sum, acc_q[XLEN-1:0]} >> BITS_PER_CYCLE);
        prod     = neg_q ? (~acc_step + AW'(1)) : acc_step;
    end

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        hi_sel_d    = hi_sel_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d    = a_neg ? (~a + XLEN'(1)) : a;
                    mplier_d   = b_neg ? (~b + XLEN'(1)) : b;
                    neg_d      = a_neg ^ b_neg;
                    hi_sel_d   = hi_sel;
                    acc_d      = '0;
                    cnt_d      = CNT_W'(N);
                    in_ready_d = 1'b0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_step;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    out_valid_d = 1'b1;
                    result_d    = hi_sel_q ? prod[AW-1:XLEN] : prod[XLEN-1:0];
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    result_d    = '0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                result_d    = '0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase

        // Abort wins over both acceptance and consumption.
        if (flush) begin
            out_valid_d = 1'b0;
            result_d    = '0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule
